// File: rtl/memory_stage_pkg.sv
// Shared opcodes, funct3 encodings and FSM states for the memory stage.
// Also holds the alignment rule, so the accept path and the lane logic use the same check.
package memory_stage_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_REQ  = 2'b01,
        MS_WAIT = 2'b10,
        MS_DONE = 2'b11
    } ms_state_t;

    // The width code 11 has no legal access size, so it is always flagged.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Combinational byte-lane logic: store strobes/replicated data, load
// extraction with sign/zero extension, and misalignment detection.
module mem_align
    import memory_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);

    logic [XLEN-1:0] shifted;

    assign misalign = is_misaligned(funct3, addr_lo);
    assign shifted  = rdata >> {addr_lo, 3'b000};

    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {(XLEN/8){store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << addr_lo;
                wdata = {(XLEN/16){store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            FUNC3_LB:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            FUNC3_LH:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            FUNC3_LBU: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            FUNC3_LHU: load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: latches the execute payload, runs one outstanding
// data-memory request per load/store, and hands aligned results to write-back.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            e_to_m_valid,
    output logic            m_allow_in,
    input  logic            w_allow_in,
    output logic            m_to_w_valid,
    output logic            m_valid,
    input  logic [XLEN-1:0] E_pc,
    input  logic [6:0]      E_opcode,
    input  logic [2:0]      E_funct3,
    input  logic [XLEN-1:0] E_valE,
    input  logic [XLEN-1:0] E_val2,
    input  logic [4:0]      E_rd,
    input  logic            E_commit,
    output logic [XLEN-1:0] M_pc,
    output logic [XLEN-1:0] M_valE,
    output logic [6:0]      M_opcode,
    output logic [4:0]      M_rd,
    output logic            M_commit,
    output logic [XLEN-1:0] m_valM,
    output logic            m_misalign,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [3:0]      dmem_req_wstrb,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata
);

    ms_state_t       state;
    ms_state_t       state_next;
    logic [2:0]      M_funct3;
    logic [XLEN-1:0] M_val2;
    logic            m_ready_go;
    logic            accept;
    logic            e_mem_go;
    logic            m_is_store;
    logic            m_is_mem;
    logic [3:0]      align_wstrb;
    logic [XLEN-1:0] align_wdata;
    logic [XLEN-1:0] align_load;
    logic            align_misalign;

    assign m_allow_in   = ~m_valid | (m_ready_go & w_allow_in);
    assign m_to_w_valid = m_valid & m_ready_go;
    assign accept       = m_allow_in & e_to_m_valid;
    assign e_mem_go     = ((E_opcode == OP_LOAD) | (E_opcode == OP_STORE))
                        & ~is_misaligned(E_funct3, E_valE[1:0]);

    assign m_is_store = (M_opcode == OP_STORE);
    assign m_is_mem   = (M_opcode == OP_LOAD) | m_is_store;

    // Request fields come from latched state, so they cannot move while REQ waits for ready.
    mem_align #(.XLEN(XLEN)) u_align (
        .funct3     (M_funct3),
        .addr_lo    (M_valE[1:0]),
        .store_data (M_val2),
        .rdata      (dmem_resp_rdata),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misalign   (align_misalign)
    );

    assign dmem_req_we    = dmem_req_valid & m_is_store;
    assign dmem_req_wstrb = dmem_req_we ? align_wstrb : 4'b0000;
    assign dmem_req_addr  = {M_valE[XLEN-1:2], 2'b00};
    assign dmem_req_wdata = align_wdata;
    assign m_misalign     = m_valid & m_is_mem & align_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MS_IDLE: if (accept && e_mem_go) state_next = MS_REQ;
            MS_REQ:  if (dmem_req_ready) state_next = m_is_store ? MS_DONE : MS_WAIT;
            MS_WAIT: if (dmem_resp_valid) state_next = MS_DONE;
            MS_DONE: begin
                if (m_to_w_valid && w_allow_in) begin
                    state_next = (accept && e_mem_go) ? MS_REQ : MS_IDLE;
                end
            end
            default: state_next = MS_IDLE;
        endcase
    end

    always_comb begin
        m_ready_go     = 1'b0;
        dmem_req_valid = 1'b0;
        case (state)
            MS_IDLE: m_ready_go = m_valid;
            MS_REQ:  dmem_req_valid = 1'b1;
            MS_DONE: m_ready_go = 1'b1;
            default: m_ready_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            M_pc     <= '0;
            M_opcode <= '0;
            M_funct3 <= '0;
            M_valE   <= '0;
            M_val2   <= '0;
            M_rd     <= '0;
            M_commit <= 1'b0;
        end else if (m_allow_in) begin
            m_valid <= e_to_m_valid;
            if (e_to_m_valid) begin
                M_pc     <= E_pc;
                M_opcode <= E_opcode;
                M_funct3 <= E_funct3;
                M_valE   <= E_valE;
                M_val2   <= E_val2;
                M_rd     <= E_rd;
                M_commit <= E_commit;
            end
        end
    end

    // Every new instruction starts with zero load data; only a WAIT response fills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valM <= '0;
        end else if (accept) begin
            m_valM <= '0;
        end else if (state == MS_WAIT && dmem_resp_valid) begin
            m_valM <= align_load;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: pass-through, store lanes, load extension,
// misalignment, handshake stalls and reset during an outstanding load.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        e_to_m_valid;
    logic        m_allow_in;
    logic        w_allow_in;
    logic        m_to_w_valid;
    logic        m_valid;
    logic [31:0] E_pc;
    logic [6:0]  E_opcode;
    logic [2:0]  E_funct3;
    logic [31:0] E_valE;
    logic [31:0] E_val2;
    logic [4:0]  E_rd;
    logic        E_commit;
    logic [31:0] M_pc;
    logic [31:0] M_valE;
    logic [6:0]  M_opcode;
    logic [4:0]  M_rd;
    logic        M_commit;
    logic [31:0] m_valM;
    logic        m_misalign;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;

    int assertions_evaluated = 0;
    int failures = 0;

    localparam logic [6:0] OP_ADD = 7'b0110011;

    memory_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .e_to_m_valid    (e_to_m_valid),
        .m_allow_in      (m_allow_in),
        .w_allow_in      (w_allow_in),
        .m_to_w_valid    (m_to_w_valid),
        .m_valid         (m_valid),
        .E_pc            (E_pc),
        .E_opcode        (E_opcode),
        .E_funct3        (E_funct3),
        .E_valE          (E_valE),
        .E_val2          (E_val2),
        .E_rd            (E_rd),
        .E_commit        (E_commit),
        .M_pc            (M_pc),
        .M_valE          (M_valE),
        .M_opcode        (M_opcode),
        .M_rd            (M_rd),
        .M_commit        (M_commit),
        .m_valM          (m_valM),
        .m_misalign      (m_misalign),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [6:0] opcode, input logic [2:0] funct3,
                                 input logic [31:0] vale, input logic [31:0] val2, input logic [4:0] rd);
        e_to_m_valid = valid;
        E_pc         = E_pc + 32'd4;
        E_opcode     = opcode;
        E_funct3     = funct3;
        E_valE       = vale;
        E_val2       = val2;
        E_rd         = rd;
        E_commit     = 1'b1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions_evaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst             = 1'b1;
        e_to_m_valid    = 1'b0;
        w_allow_in      = 1'b1;
        E_pc            = 32'h0000_0100;
        E_opcode        = 7'd0;
        E_funct3        = 3'd0;
        E_valE          = 32'd0;
        E_val2          = 32'd0;
        E_rd            = 5'd0;
        E_commit        = 1'b0;
        dmem_req_ready  = 1'b1;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'd0;

        #3;
        checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        checkOutput("rst_req_we", {31'd0, dmem_req_we}, 32'd0);
        checkOutput("rst_wstrb", {28'd0, dmem_req_wstrb}, 32'd0);
        checkOutput("rst_valM", m_valM, 32'd0);
        checkOutput("rst_misalign", {31'd0, m_misalign}, 32'd0);
        checkOutput("rst_M_valE", M_valE, 32'd0);
        checkOutput("rst_M_pc", M_pc, 32'd0);
        checkOutput("rst_allow_in", {31'd0, m_allow_in}, 32'd1);
        tick();
        rst = 1'b0;

        // ADD passes through in one cycle
        applyStimulus(1'b1, OP_ADD, 3'b000, 32'h0000_1234, 32'd0, 5'd3);
        tick();
        e_to_m_valid = 1'b0;
        #1;
        checkOutput("add_to_w_valid", {31'd0, m_to_w_valid}, 32'd1);
        checkOutput("add_M_valE", M_valE, 32'h0000_1234);
        checkOutput("add_M_rd", {27'd0, M_rd}, 32'd3);
        checkOutput("add_no_req", {31'd0, dmem_req_valid}, 32'd0);
        checkOutput("add_valM", m_valM, 32'd0);
        tick();
        checkOutput("add_drained", {31'd0, m_valid}, 32'd0);

        // SB at 0x1003 with ready high
        applyStimulus(1'b1, OP_STORE, FUNC3_SB, 32'h0000_1003, 32'h1234_56AB, 5'd0);
        tick();
        e_to_m_valid = 1'b0;
        #1;
        checkOutput("sb_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        checkOutput("sb_addr", dmem_req_addr, 32'h0000_1000);
        checkOutput("sb_we", {31'd0, dmem_req_we}, 32'd1);
        checkOutput("sb_wstrb", {28'd0, dmem_req_wstrb}, 32'h8);
        checkOutput("sb_wdata", dmem_req_wdata, 32'hABAB_ABAB);
        checkOutput("sb_not_done", {31'd0, m_to_w_valid}, 32'd0);
        checkOutput("sb_allow_in", {31'd0, m_allow_in}, 32'd0);
        tick();
        checkOutput("sb_to_w_valid", {31'd0, m_to_w_valid}, 32'd1);
        checkOutput("sb_req_dropped", {31'd0, dmem_req_valid}, 32'd0);
        tick();
        checkOutput("sb_drained", {31'd0, m_valid}, 32'd0);

        // LB at 0x1002, response two cycles after the request
        applyStimulus(1'b1, OP_LOAD, FUNC3_LB, 32'h0000_1002, 32'd0, 5'd5);
        tick();
        e_to_m_valid = 1'b0;
        #1;
        checkOutput("lb_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        checkOutput("lb_addr", dmem_req_addr, 32'h0000_1000);
        checkOutput("lb_we", {31'd0, dmem_req_we}, 32'd0);
        checkOutput("lb_wstrb", {28'd0, dmem_req_wstrb}, 32'd0);
        tick();
        checkOutput("lb_wait_no_req", {31'd0, dmem_req_valid}, 32'd0);
        tick();
        checkOutput("lb_wait_not_done", {31'd0, m_to_w_valid}, 32'd0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h0080_0000;
        tick();
        dmem_resp_valid = 1'b0;
        #1;
        checkOutput("lb_valM", m_valM, 32'hFFFF_FF80);
        checkOutput("lb_to_w_valid", {31'd0, m_to_w_valid}, 32'd1);

        // LBU accepted in the same cycle the LB leaves DONE
        applyStimulus(1'b1, OP_LOAD, FUNC3_LBU, 32'h0000_1002, 32'd0, 5'd6);
        checkOutput("lbu_allow_in", {31'd0, m_allow_in}, 32'd1);
        tick();
        e_to_m_valid = 1'b0;
        #1;
        checkOutput("lbu_req_valid", {31'd0, dmem_req_valid}, 32'd1);
        checkOutput("lbu_valM_cleared", m_valM, 32'd0);
        tick();
        dmem_resp_valid = 1'b1;
        tick();
        dmem_resp_valid = 1'b0;
        #1;
        checkOutput("lbu_valM", m_valM, 32'h0000_0080);
        tick();
        checkOutput("lbu_drained", {31'd0, m_valid}, 32'd0);

        // Misaligned LW passes through with no request
        applyStimulus(1'b1, OP_LOAD, FUNC3_LW, 32'h0000_2002, 32'd0, 5'd7);
        tick();
        e_to_m_valid = 1'b0;
        #1;
        checkOutput("mis_flag", {31'd0, m_misalign}, 32'd1);
        checkOutput("mis_no_req", {31'd0, dmem_req_valid}, 32'd0);
        checkOutput("mis_to_w_valid", {31'd0, m_to_w_valid}, 32'd1);
        checkOutput("mis_valM", m_valM, 32'd0);
        tick();
        checkOutput("mis_drained", {31'd0, m_valid}, 32'd0);
        checkOutput("mis_flag_clear", {31'd0, m_misalign}, 32'd0);

        // LW with ready low for three cycles and write-back stalled for two
        dmem_req_ready = 1'b0;
        applyStimulus(1'b1, OP_LOAD, FUNC3_LW, 32'h0000_3000, 32'd0, 5'd8);
        tick();
        e_to_m_valid = 1'b0;
        E_valE = 32'hDEAD_BEEF;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall_req_valid_%0d", i), {31'd0, dmem_req_valid}, 32'd1);
            checkOutput($sformatf("stall_addr_%0d", i), dmem_req_addr, 32'h0000_3000);
            checkOutput($sformatf("stall_allow_in_%0d", i), {31'd0, m_allow_in}, 32'd0);
            tick();
        end
        dmem_req_ready = 1'b1;
        #1;
        checkOutput("stall_req_still", {31'd0, dmem_req_valid}, 32'd1);
        tick();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hCAFE_F00D;
        w_allow_in      = 1'b0;
        tick();
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h1111_1111;
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("hold_valM_%0d", i), m_valM, 32'hCAFE_F00D);
            checkOutput($sformatf("hold_to_w_valid_%0d", i), {31'd0, m_to_w_valid}, 32'd1);
            checkOutput($sformatf("hold_allow_in_%0d", i), {31'd0, m_allow_in}, 32'd0);
            tick();
        end
        w_allow_in = 1'b1;
        #1;
        checkOutput("hold_release", {31'd0, m_allow_in}, 32'd1);
        tick();
        checkOutput("hold_drained", {31'd0, m_valid}, 32'd0);

        // Reset while a load sits in WAIT; the late response must be ignored
        dmem_req_ready = 1'b1;
        applyStimulus(1'b1, OP_LOAD, FUNC3_LW, 32'h0000_4000, 32'd0, 5'd9);
        tick();
        e_to_m_valid = 1'b0;
        tick();
        checkOutput("wait_occupied", {31'd0, m_valid}, 32'd1);
        checkOutput("wait_no_req", {31'd0, dmem_req_valid}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("midrst_M_valE", M_valE, 32'd0);
        checkOutput("midrst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        checkOutput("midrst_valM", m_valM, 32'd0);
        tick();
        rst = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_resp_valid = 1'b0;
        #1;
        checkOutput("stale_valM", m_valM, 32'd0);
        checkOutput("stale_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("stale_to_w_valid", {31'd0, m_to_w_valid}, 32'd0);
        checkOutput("stale_req_valid", {31'd0, dmem_req_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions_evaluated, failures);
        $finish;
    end

endmodule
